// File: rtl/decode_ibuf_credit_ctrl.sv
// Credit throttle between decode and the per-warp ibuffers, with a per-warp drain sequencer.
// Optional DECODE_CREDIT_PERF_EN adds saturating stall and drain cycle counters.
//
// state | meaning
// IDLE  | no drain in progress, accepts drain_req
// DRAIN | pushes to drain_wid_q blocked, waiting for its occupancy to reach 0
// DONE  | one-cycle completion pulse, then back to IDLE
module decode_ibuf_credit_ctrl #(
  parameter int NUM_WARPS  = 4,
  parameter int IBUF_DEPTH = 2,
  parameter int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CNT_W      = $clog2(IBUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_in_valid,
  input  logic [WID_W-1:0]     dec_in_wid,
  output logic                 dec_in_ready,
  output logic                 dec_out_valid,
  input  logic                 dec_out_ready,
  input  logic [NUM_WARPS-1:0] ibuf_pop,
  output logic [NUM_WARPS-1:0] warp_full,
  output logic [NUM_WARPS-1:0] warp_empty,
  input  logic                 drain_req,
  input  logic [WID_W-1:0]     drain_wid,
  output logic                 drain_busy,
  output logic                 drain_done,
`ifdef DECODE_CREDIT_PERF_EN
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_drain_cycles,
`endif
  output logic                 pop_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IBUF_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_e;

  state_e                          state_q, state_d;
  logic [NUM_WARPS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_WARPS-1:0]            warp_full_q, warp_full_d;
  logic [NUM_WARPS-1:0]            warp_empty_q, warp_empty_d;
  logic [WID_W-1:0]                drain_wid_q, drain_wid_d;
  logic                            drain_busy_q, drain_busy_d;
  logic                            drain_done_q, drain_done_d;
  logic                            pop_err_q, pop_err_d;

  logic [CNT_W-1:0]     cnt_sel;
  logic [CNT_W-1:0]     cnt_drain;
  logic                 blocked;
  logic                 push;
  logic [NUM_WARPS-1:0] push_vec;

  always_comb begin
    cnt_sel   = '0;
    cnt_drain = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (dec_in_wid == WID_W'(w)) cnt_sel = cnt_q[w];
      if (drain_wid_q == WID_W'(w)) cnt_drain = cnt_q[w];
    end
    blocked       = (cnt_sel == FULL_CNT) || (drain_busy_q && (dec_in_wid == drain_wid_q));
    dec_out_valid = dec_in_valid & ~blocked;
    dec_in_ready  = dec_out_ready & ~blocked;
    push          = dec_out_valid & dec_out_ready;
  end

  // A same-cycle push and pop on one warp cancel; an unmatched pop on an empty warp only flags.
  always_comb begin
    cnt_d     = cnt_q;
    pop_err_d = pop_err_q;
    push_vec  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_vec[w] = push && (dec_in_wid == WID_W'(w));
      if (push_vec[w] && !ibuf_pop[w]) begin
        cnt_d[w] = cnt_q[w] + CNT_W'(1);
      end else if (!push_vec[w] && ibuf_pop[w]) begin
        if (cnt_q[w] == '0) pop_err_d = 1'b1;
        else                cnt_d[w] = cnt_q[w] - CNT_W'(1);
      end
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_full_d[w]  = (cnt_d[w] == FULL_CNT);
      warp_empty_d[w] = (cnt_d[w] == '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_wid_d = drain_wid_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_req) begin
          drain_wid_d = drain_wid;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: if (cnt_drain == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    drain_busy_d = (state_d == ST_DRAIN);
    drain_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      warp_full_q  <= '0;
      warp_empty_q <= '1;
      drain_wid_q  <= '0;
      drain_busy_q <= 1'b0;
      drain_done_q <= 1'b0;
      pop_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      warp_full_q  <= warp_full_d;
      warp_empty_q <= warp_empty_d;
      drain_wid_q  <= drain_wid_d;
      drain_busy_q <= drain_busy_d;
      drain_done_q <= drain_done_d;
      pop_err_q    <= pop_err_d;
    end
  end

  assign warp_full  = warp_full_q;
  assign warp_empty = warp_empty_q;
  assign drain_busy = drain_busy_q;
  assign drain_done = drain_done_q;
  assign pop_err    = pop_err_q;

`ifdef DECODE_CREDIT_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_drain_q, perf_drain_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_drain_d = perf_drain_q;
    if (dec_in_valid && blocked && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if ((state_q == ST_DRAIN) && (perf_drain_q != '1))   perf_drain_d = perf_drain_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_drain_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_drain_q <= perf_drain_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_drain_cycles = perf_drain_q;
`endif

endmodule

// File: tb/tb_decode_ibuf_credit_ctrl.sv
// Directed bench for decode_ibuf_credit_ctrl: vector table for credit accounting,
// hand sequences for drain, ignored requests and asynchronous reset.
module tb_decode_ibuf_credit_ctrl;

  logic       clk;
  logic       reset;
  logic       dec_in_valid;
  logic [1:0] dec_in_wid;
  logic       dec_in_ready;
  logic       dec_out_valid;
  logic       dec_out_ready;
  logic [3:0] ibuf_pop;
  logic [3:0] warp_full;
  logic [3:0] warp_empty;
  logic       drain_req;
  logic [1:0] drain_wid;
  logic       drain_busy;
  logic       drain_done;
  logic       pop_err;

  int checks = 0;
  int errors = 0;

  decode_ibuf_credit_ctrl #(.NUM_WARPS(4), .IBUF_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_in_valid (dec_in_valid),
    .dec_in_wid   (dec_in_wid),
    .dec_in_ready (dec_in_ready),
    .dec_out_valid(dec_out_valid),
    .dec_out_ready(dec_out_ready),
    .ibuf_pop     (ibuf_pop),
    .warp_full    (warp_full),
    .warp_empty   (warp_empty),
    .drain_req    (drain_req),
    .drain_wid    (drain_wid),
    .drain_busy   (drain_busy),
    .drain_done   (drain_done),
    .pop_err      (pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] wid;
    logic       rdy;
    logic [3:0] pop;
    logic       ov;
    logic       ir;
    logic [3:0] full;
    logic [3:0] empty;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic v, logic [1:0] wid, logic rdy, logic [3:0] pop,
                              logic ov, logic ir, logic [3:0] full, logic [3:0] empty, logic err);
    vec_t r;
    r.v = v; r.wid = wid; r.rdy = rdy; r.pop = pop;
    r.ov = ov; r.ir = ir; r.full = full; r.empty = empty; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic drive(input logic v, input logic [1:0] wid, input logic rdy,
                       input logic [3:0] pop, input logic dreq, input logic [1:0] dwid);
    @(negedge clk);
    dec_in_valid  = v;
    dec_in_wid    = wid;
    dec_out_ready = rdy;
    ibuf_pop      = pop;
    drain_req     = dreq;
    drain_wid     = dwid;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Registered columns show state before this vector's clock edge.
    vecs[0]  = mk(1, 2'd1, 1, 4'b0000, 1, 1, 4'b0000, 4'b1111, 0);
    vecs[1]  = mk(1, 2'd1, 1, 4'b0000, 1, 1, 4'b0000, 4'b1101, 0);
    vecs[2]  = mk(1, 2'd1, 1, 4'b0000, 0, 0, 4'b0010, 4'b1101, 0);
    vecs[3]  = mk(1, 2'd1, 1, 4'b0000, 0, 0, 4'b0010, 4'b1101, 0);
    vecs[4]  = mk(1, 2'd1, 1, 4'b0010, 0, 0, 4'b0010, 4'b1101, 0);
    vecs[5]  = mk(1, 2'd1, 1, 4'b0000, 1, 1, 4'b0000, 4'b1101, 0);
    vecs[6]  = mk(0, 2'd1, 1, 4'b0000, 0, 0, 4'b0010, 4'b1101, 0);
    vecs[7]  = mk(1, 2'd2, 1, 4'b0000, 1, 1, 4'b0010, 4'b1101, 0);
    vecs[8]  = mk(1, 2'd2, 1, 4'b0100, 1, 1, 4'b0010, 4'b1001, 0);
    vecs[9]  = mk(0, 2'd0, 1, 4'b0000, 1'b0, 1, 4'b0010, 4'b1001, 0);
    vecs[10] = mk(0, 2'd0, 1, 4'b1000, 0, 1, 4'b0010, 4'b1001, 0);
    vecs[11] = mk(0, 2'd0, 1, 4'b0000, 0, 1, 4'b0010, 4'b1001, 1);
    vecs[12] = mk(1, 2'd0, 0, 4'b0000, 1, 0, 4'b0010, 4'b1001, 1);
    vecs[13] = mk(0, 2'd0, 1, 4'b0110, 0, 1, 4'b0010, 4'b1001, 1);
    vecs[14] = mk(0, 2'd0, 1, 4'b0000, 0, 1, 4'b0000, 4'b1101, 1);

    reset = 1'b0;
    dec_in_valid = 1'b0; dec_in_wid = '0; dec_out_ready = 1'b0;
    ibuf_pop = '0; drain_req = 1'b0; drain_wid = '0;
    #12;
    chk("rst_full",  32'(warp_full),  32'h0);
    chk("rst_empty", 32'(warp_empty), 32'hf);
    chk("rst_busy",  32'(drain_busy), 32'h0);
    chk("rst_done",  32'(drain_done), 32'h0);
    chk("rst_err",   32'(pop_err),    32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].wid, vecs[i].rdy, vecs[i].pop, 1'b0, 2'd0);
      chk($sformatf("vec%0d_out_valid", i), 32'(dec_out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_in_ready", i),  32'(dec_in_ready),  32'(vecs[i].ir));
      chk($sformatf("vec%0d_full", i),      32'(warp_full),     32'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i),     32'(warp_empty),    32'(vecs[i].empty));
      chk($sformatf("vec%0d_pop_err", i),   32'(pop_err),       32'(vecs[i].err));
      tick();
    end

    // Drain of a warp holding 2 entries; cnt1=1 at this point.
    drive(1, 2'd0, 1, 4'b0000, 0, 2'd0); tick();
    drive(1, 2'd0, 1, 4'b0000, 0, 2'd0); tick();
    drive(0, 2'd0, 1, 4'b0000, 1, 2'd0);
    chk("drn_full0", 32'(warp_full[0]), 32'h1);
    chk("drn_busy_at_req", 32'(drain_busy), 32'h0);
    tick();
    drive(1, 2'd0, 1, 4'b0000, 0, 2'd0);
    chk("drn_busy", 32'(drain_busy), 32'h1);
    chk("drn_w0_blocked_ov", 32'(dec_out_valid), 32'h0);
    chk("drn_w0_blocked_ir", 32'(dec_in_ready), 32'h0);
    tick();
    drive(1, 2'd1, 1, 4'b0000, 0, 2'd0);
    chk("drn_w1_ov", 32'(dec_out_valid), 32'h1);
    chk("drn_w1_ir", 32'(dec_in_ready), 32'h1);
    tick();
    drive(0, 2'd0, 1, 4'b0001, 0, 2'd0);
    chk("drn_w1_full", 32'(warp_full[1]), 32'h1);
    chk("drn_done_early1", 32'(drain_done), 32'h0);
    tick();
    drive(0, 2'd0, 1, 4'b0001, 0, 2'd0);
    chk("drn_busy_mid", 32'(drain_busy), 32'h1);
    chk("drn_done_early2", 32'(drain_done), 32'h0);
    tick();
    drive(0, 2'd0, 1, 4'b0000, 0, 2'd0);
    chk("drn_empty0", 32'(warp_empty[0]), 32'h1);
    chk("drn_busy_at_zero", 32'(drain_busy), 32'h1);
    chk("drn_done_at_zero", 32'(drain_done), 32'h0);
    tick();
    drive(1, 2'd0, 0, 4'b0000, 0, 2'd0);
    chk("drn_done_pulse", 32'(drain_done), 32'h1);
    chk("drn_busy_in_done", 32'(drain_busy), 32'h0);
    chk("drn_w0_unblocked", 32'(dec_out_valid), 32'h1);
    tick();
    drive(0, 2'd0, 1, 4'b0000, 0, 2'd0);
    chk("drn_done_once", 32'(drain_done), 32'h0);
    chk("drn_err_sticky", 32'(pop_err), 32'h1);
    tick();

    // Drain of an already-empty warp; a second request while busy is dropped.
    drive(0, 2'd0, 1, 4'b0000, 1, 2'd3);
    chk("edrn_busy_at_req", 32'(drain_busy), 32'h0);
    tick();
    drive(1, 2'd3, 0, 4'b0000, 1, 2'd1);
    chk("edrn_busy", 32'(drain_busy), 32'h1);
    chk("edrn_done_early", 32'(drain_done), 32'h0);
    chk("edrn_w3_blocked", 32'(dec_out_valid), 32'h0);
    tick();
    drive(0, 2'd0, 1, 4'b0000, 0, 2'd0);
    chk("edrn_done_pulse", 32'(drain_done), 32'h1);
    chk("edrn_busy_off", 32'(drain_busy), 32'h0);
    tick();
    drive(0, 2'd0, 1, 4'b0000, 0, 2'd0);
    chk("ignored_req_busy", 32'(drain_busy), 32'h0);
    chk("ignored_req_done", 32'(drain_done), 32'h0);
    tick();

    // Asynchronous reset mid-drain with cnt0=1, cnt1=2.
    drive(1, 2'd0, 1, 4'b0000, 0, 2'd0); tick();
    drive(0, 2'd0, 1, 4'b0000, 1, 2'd0); tick();
    drive(1, 2'd0, 0, 4'b0000, 0, 2'd0);
    chk("pre_rst_busy", 32'(drain_busy), 32'h1);
    chk("pre_rst_empty", 32'(warp_empty), 32'hc);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy",  32'(drain_busy), 32'h0);
    chk("arst_done",  32'(drain_done), 32'h0);
    chk("arst_err",   32'(pop_err),    32'h0);
    chk("arst_full",  32'(warp_full),  32'h0);
    chk("arst_empty", 32'(warp_empty), 32'hf);
    chk("arst_w0_ov", 32'(dec_out_valid), 32'h1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 2'd1, 1, 4'b0000, 0, 2'd0);
    chk("post_rst_ov", 32'(dec_out_valid), 32'h1);
    chk("post_rst_ir", 32'(dec_in_ready), 32'h1);
    tick();
    drive(0, 2'd0, 1, 4'b0000, 0, 2'd0);
    chk("post_rst_empty", 32'(warp_empty), 32'hd);
    chk("post_rst_full",  32'(warp_full),  32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
